// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single-port memory
//
// Ports:
//   clk, nReset                      clock, asynchronous active-low reset
//   rN_req/rN_rw/rN_addr/rN_wdata    requester N transaction request (rw: 1=read, 0=write)
//   rN_ack                           one-cycle completion pulse to requester N
//   rdata                            shared read data, valid alongside a read ack
//   busy                             high whenever the FSM is not idle
//   memEN/memRW/memAddr/memWrite     memory command, memEN pulses for one cycle per access
//   memBus                           memory read data, valid MEM_LAT cycles after memEN
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 256,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              r0_req,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              memEN,
    output logic              memRW,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrite,
    input  logic [DATA_W-1:0] memBus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant_id;
    logic       winner;

    // On a tie the requester that was not served last wins; otherwise the
    // only active requester wins.
    always_comb begin
        winner     = 1'b0;
        state_next = state;
        if (r0_req && r1_req) begin
            winner = ~last_grant;
        end else begin
            winner = r1_req;
        end
        case (state)
            S_IDLE:  if (r0_req || r1_req) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // memRW/memAddr/memWrite double as the transaction latch: they are only
    // loaded on a grant and hold their value for the rest of the transaction.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            memEN      <= 1'b0;
            memRW      <= 1'b1;
            memAddr    <= '0;
            memWrite   <= '0;
            rdata      <= '0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (r0_req || r1_req) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        memEN      <= 1'b1;
                        memRW      <= winner ? r1_rw    : r0_rw;
                        memAddr    <= winner ? r1_addr  : r0_addr;
                        memWrite   <= winner ? r1_wdata : r0_wdata;
                    end
                end
                S_ISSUE: begin
                    memEN <= 1'b0;
                    cnt   <= LAT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (memRW) begin
                            rdata <= memBus;
                        end
                        r0_ack <= ~grant_id;
                        r1_ack <= grant_id;
                    end
                end
                S_RESP: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                end
                default: begin
                    memEN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          r0_req = 1'b0, r0_rw = 1'b1, r1_req = 1'b0, r1_rw = 1'b1;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_ack, r1_ack, busy, memEN, memRW;
    logic [DW-1:0] rdata, memWrite;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memBus = '0;

    logic          l_req = 1'b0, l_rw = 1'b1;
    logic [AW-1:0] l_addr = '0;
    logic          l_ack0, l_ack1, l_busy, l_memEN, l_memRW;
    logic [DW-1:0] l_rdata, l_memWrite;
    logic [AW-1:0] l_memAddr;
    logic [DW-1:0] l_memBus = '0;

    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] PAT_AB = {32{8'hAB}};
    localparam logic [DW-1:0] PAT_55 = {32{8'h55}};
    localparam logic [DW-1:0] PAT_77 = {32{8'h77}};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .clk(clk), .nReset(nReset),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .busy(busy),
        .memEN(memEN), .memRW(memRW), .memAddr(memAddr), .memWrite(memWrite),
        .memBus(memBus)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_lat3 (
        .clk(clk), .nReset(nReset),
        .r0_req(l_req), .r0_rw(l_rw), .r0_addr(l_addr), .r0_wdata('0),
        .r1_req(1'b0), .r1_rw(1'b1), .r1_addr('0), .r1_wdata('0),
        .r0_ack(l_ack0), .r1_ack(l_ack1), .rdata(l_rdata), .busy(l_busy),
        .memEN(l_memEN), .memRW(l_memRW), .memAddr(l_memAddr), .memWrite(l_memWrite),
        .memBus(l_memBus)
    );

    // Memory model: access registered on the edge that sees memEN high;
    // read data then stays on the bus until the next read.
    always @(posedge clk) begin
        if (memEN) begin
            if (memRW) memBus <= mem[memAddr];
            else       mem[memAddr] <= memWrite;
        end
        if (l_memEN && l_memRW) l_memBus <= mem[l_memAddr];
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        nReset = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0; l_req = 1'b0;
        tick; tick;
        nReset = 1'b1;
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        tick;
        checks++; if (memEN !== 1'b0) begin errors++; $display("FAIL reset_memEN got %b want 0", memEN); end
        checks++; if (memRW !== 1'b1) begin errors++; $display("FAIL reset_memRW got %b want 1", memRW); end
        checks++; if (memAddr !== '0 || memWrite !== '0 || rdata !== '0) begin
            errors++; $display("FAIL reset_data memAddr %h memWrite %h rdata %h want 0", memAddr, memWrite, rdata); end
        checks++; if ({r0_ack, r1_ack, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ack_busy got %b want 000", {r0_ack, r1_ack, busy}); end
    endtask

    task automatic test_read;
        do_reset;
        r0_rw = 1'b1; r0_addr = 8'h03; r0_req = 1'b1;
        tick;
        checks++; if ({memEN, memRW, busy} !== 3'b111 || memAddr !== 8'h03) begin
            errors++; $display("FAIL read_issue en/rw/busy %b addr %h want 111 03", {memEN, memRW, busy}, memAddr); end
        tick;
        checks++; if (memEN !== 1'b0 || r0_ack !== 1'b0) begin
            errors++; $display("FAIL read_wait memEN %b r0_ack %b want 0 0", memEN, r0_ack); end
        tick;
        checks++; if (r0_ack !== 1'b1 || r1_ack !== 1'b0) begin
            errors++; $display("FAIL read_ack r0 %b r1 %b want 1 0", r0_ack, r1_ack); end
        checks++; if (rdata !== PAT_AB) begin errors++; $display("FAIL read_rdata got %h want %h", rdata, PAT_AB); end
        r0_req = 1'b0;
        tick;
        checks++; if (r0_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL read_idle r0_ack %b busy %b want 0 0", r0_ack, busy); end
    endtask

    task automatic test_write_read;
        r1_rw = 1'b0; r1_addr = 8'h05; r1_wdata = PAT_55; r1_req = 1'b1;
        tick;
        checks++; if (memEN !== 1'b1 || memRW !== 1'b0 || memAddr !== 8'h05 || memWrite !== PAT_55) begin
            errors++; $display("FAIL write_issue en %b rw %b addr %h data %h", memEN, memRW, memAddr, memWrite); end
        tick; tick;
        checks++; if (r1_ack !== 1'b1 || r0_ack !== 1'b0) begin
            errors++; $display("FAIL write_ack r1 %b r0 %b want 1 0", r1_ack, r0_ack); end
        checks++; if (rdata !== PAT_AB) begin errors++; $display("FAIL write_rdata_kept got %h want %h", rdata, PAT_AB); end
        r1_req = 1'b0;
        tick;
        r0_rw = 1'b1; r0_addr = 8'h05; r0_req = 1'b1;
        tick; tick; tick;
        checks++; if (r0_ack !== 1'b1 || rdata !== PAT_55) begin
            errors++; $display("FAIL readback r0_ack %b rdata %h want 1 %h", r0_ack, rdata, PAT_55); end
        r0_req = 1'b0;
        tick;
    endtask

    task automatic test_addr_change;
        r0_rw = 1'b1; r0_addr = 8'h03; r0_req = 1'b1;
        tick;
        r0_addr = 8'h07;
        checks++; if (memAddr !== 8'h03) begin errors++; $display("FAIL addr_latch_c1 got %h want 03", memAddr); end
        tick;
        checks++; if (memAddr !== 8'h03) begin errors++; $display("FAIL addr_latch_c2 got %h want 03", memAddr); end
        tick;
        checks++; if (r0_ack !== 1'b1 || rdata !== PAT_AB) begin
            errors++; $display("FAIL addr_latch_data ack %b rdata %h want 1 %h", r0_ack, rdata, PAT_AB); end
        r0_req = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        int en_cyc[$];
        int order[$];
        bit overlap = 0;
        nReset = 1'b0;
        tick;
        r0_rw = 1'b1; r0_addr = 8'h03; r1_rw = 1'b1; r1_addr = 8'h05;
        r0_req = 1'b1; r1_req = 1'b1;
        tick;
        nReset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (memEN) en_cyc.push_back(c);
            if (r0_ack && r1_ack) overlap = 1;
            if (r0_ack) order.push_back(0);
            if (r1_ack) order.push_back(1);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++; if (order.size() < 4) begin
            errors++; $display("FAIL rr_ack_count got %0d want >=4", order.size()); end
        else begin
            checks++; if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
                errors++; $display("FAIL rr_order got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]); end
        end
        checks++; if (overlap) begin errors++; $display("FAIL rr_overlap got 1 want 0"); end
        checks++; if (en_cyc.size() < 4) begin
            errors++; $display("FAIL rr_en_count got %0d want >=4", en_cyc.size()); end
        else begin
            checks++; if (en_cyc[0] != 1 || en_cyc[1] != 5 || en_cyc[2] != 9 || en_cyc[3] != 13) begin
                errors++; $display("FAIL rr_en_spacing got %0d %0d %0d %0d want 1 5 9 13",
                                   en_cyc[0], en_cyc[1], en_cyc[2], en_cyc[3]); end
        end
    endtask

    task automatic test_reset_in_wait;
        bit acked = 0;
        do_reset;
        r0_rw = 1'b1; r0_addr = 8'h07; r0_req = 1'b1;
        tick; tick;
        nReset = 1'b0;
        #1;
        checks++; if ({busy, memEN, memRW, r0_ack, r1_ack} !== 5'b00100 || memAddr !== '0 || rdata !== '0) begin
            errors++; $display("FAIL rst_wait_outputs b/en/rw/a0/a1 %b addr %h rdata %h want 00100 00 0",
                               {busy, memEN, memRW, r0_ack, r1_ack}, memAddr, rdata); end
        r0_req = 1'b0;
        for (int c = 0; c < 3; c++) begin tick; if (r0_ack || r1_ack) acked = 1; end
        nReset = 1'b1;
        for (int c = 0; c < 3; c++) begin tick; if (r0_ack || r1_ack) acked = 1; end
        checks++; if (acked) begin errors++; $display("FAIL rst_wait_no_ack got 1 want 0"); end
        r0_addr = 8'h03; r0_req = 1'b1;
        tick; tick; tick;
        checks++; if (r0_ack !== 1'b1 || rdata !== PAT_AB) begin
            errors++; $display("FAIL rst_wait_recover ack %b rdata %h want 1 %h", r0_ack, rdata, PAT_AB); end
        r0_req = 1'b0;
        tick;
    endtask

    task automatic test_latency3;
        int n_en = 0;
        int ack_c = -1;
        do_reset;
        l_rw = 1'b1; l_addr = 8'h07; l_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick;
            if (l_memEN) n_en++;
            if (l_ack0 && ack_c < 0) begin
                ack_c = c;
                checks++; if (l_rdata !== PAT_77) begin
                    errors++; $display("FAIL lat3_rdata got %h want %h", l_rdata, PAT_77); end
                l_req = 1'b0;
            end
        end
        l_req = 1'b0;
        checks++; if (ack_c != 5) begin errors++; $display("FAIL lat3_ack_cycle got %0d want 5", ack_c); end
        checks++; if (n_en != 1) begin errors++; $display("FAIL lat3_en_pulses got %0d want 1", n_en); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[3] = PAT_AB;
        mem[7] = PAT_77;
        test_reset;
        test_read;
        test_write_read;
        test_addr_change;
        test_round_robin;
        test_reset_in_wait;
        test_latency3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
